// File: rtl/hex_display_if.sv
// Bus between the register/debug side and the 7-segment driver.
// The master supplies the value and enable; the slave returns the pin drive.
interface hex_display_if;
    logic [15:0] data;
    logic        enable;
    logic [7:0]  seg;
    logic [3:0]  anode;

    modport master (output data, output enable, input seg, input anode);
    modport slave  (input data, input enable, output seg, output anode);
endinterface

// File: rtl/hex_display.sv
// Four-digit time-multiplexed driver for a common-anode 7-segment display.
// Segment and anode outputs are active-low; enable blanks without pausing the scan.
module hex_display #(
    parameter int CLKS_PER_DIGIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    hex_display_if.slave  bus
);

    localparam int DIV_W = (CLKS_PER_DIGIT > 1) ? $clog2(CLKS_PER_DIGIT) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_DIGIT - 1);

    logic [DIV_W-1:0] div;
    logic [1:0]       idx;
    logic [3:0]       nibble;
    logic [7:0]       seg_drive;
    logic [3:0]       anode_drive;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] value);
        logic [7:0] pattern;
        case (value)
            4'h0:    pattern = 8'hC0;
            4'h1:    pattern = 8'hF9;
            4'h2:    pattern = 8'hA4;
            4'h3:    pattern = 8'hB0;
            4'h4:    pattern = 8'h99;
            4'h5:    pattern = 8'h92;
            4'h6:    pattern = 8'h82;
            4'h7:    pattern = 8'hF8;
            4'h8:    pattern = 8'h80;
            4'h9:    pattern = 8'h90;
            4'hA:    pattern = 8'h88;
            4'hB:    pattern = 8'h83;
            4'hC:    pattern = 8'hC6;
            4'hD:    pattern = 8'hA1;
            4'hE:    pattern = 8'h86;
            default: pattern = 8'h8E;
        endcase
        return pattern;
    endfunction

    // Scan keeps running while blanked so re-enabling lands on the live digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div <= '0;
            idx <= '0;
        end else if (div == DIV_LAST) begin
            div <= '0;
            idx <= idx + 2'd1;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    always_comb begin
        nibble = bus.data[3:0];
        case (idx)
            2'd0:    nibble = bus.data[3:0];
            2'd1:    nibble = bus.data[7:4];
            2'd2:    nibble = bus.data[11:8];
            default: nibble = bus.data[15:12];
        endcase
    end

    always_comb begin
        seg_drive   = 8'hFF;
        anode_drive = 4'b1111;
        if (bus.enable) begin
            seg_drive   = hex_to_seg(nibble);
            anode_drive = ~(4'b0001 << idx);
        end
    end

    assign bus.seg   = seg_drive;
    assign bus.anode = anode_drive;

endmodule

// File: tb/tb_hex_display.sv
// Self-checking bench for hex_display: vector table plus scoreboard queue,
// covering scan order, blanking, encoding, async reset, live data and fast scan.
module tb_hex_display;

    typedef struct {
        logic       sel;
        logic [3:0] anode;
        logic [7:0] seg;
    } exp_t;

    typedef struct {
        logic [15:0] data;
        logic        enable;
        logic [3:0]  anode;
        logic [7:0]  seg;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    hex_display_if bus4 ();
    hex_display_if bus1 ();

    hex_display #(.CLKS_PER_DIGIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    hex_display #(.CLKS_PER_DIGIT(1)) dut_fast (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    logic [7:0] hex_table [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                   8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Reference: digit = (cycles since reset / dwell) mod 4, nibble picked by shifting.
    function automatic exp_t model(input logic [15:0] d, input logic en, input int c);
        exp_t e;
        int   i;
        logic [3:0] nib;
        i   = (c / 4) % 4;
        nib = 4'(d >> (4 * i));
        e.sel = 1'b0;
        if (en) begin
            e.anode = 4'hF & ~(4'b0001 << i);
            e.seg   = hex_table[nib];
        end else begin
            e.anode = 4'b1111;
            e.seg   = 8'hFF;
        end
        return e;
    endfunction

    task automatic apply_stimulus(input logic [15:0] d, input logic en, input exp_t e);
        bus4.data   = d;
        bus4.enable = en;
        bus1.data   = d;
        bus1.enable = en;
        sb.push_back(e);
    endtask

    task automatic check_output(input string name);
        exp_t       e;
        logic [3:0] act_anode;
        logic [7:0] act_seg;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s scoreboard empty got 0 entries want 1", name);
        end else begin
            e         = sb.pop_front();
            act_anode = e.sel ? bus1.anode : bus4.anode;
            act_seg   = e.sel ? bus1.seg   : bus4.seg;
            checks++;
            if (act_anode !== e.anode) begin
                errors++;
                $display("[TB] FAIL %s anode got %b want %b (t=%0t)", name, act_anode, e.anode, $time);
            end
            checks++;
            if (act_seg !== e.seg) begin
                errors++;
                $display("[TB] FAIL %s seg got %h want %h (t=%0t)", name, act_seg, e.seg, $time);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        vec_t       vecs [17];
        logic [3:0] scan_anodes [4];
        logic [7:0] scan_segs [4];
        logic [3:0] fast_anodes [5];
        logic [7:0] fast_segs [5];
        exp_t       e;

        scan_anodes = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        scan_segs   = '{8'h99, 8'h82, 8'h8E, 8'h88};
        for (int k = 0; k < 17; k++)
            vecs[k] = '{16'hAF64, 1'b1, scan_anodes[(k / 4) % 4], scan_segs[(k / 4) % 4]};
        fast_anodes = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        fast_segs   = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'hF9};

        $display("[TB] starting hex_display bench");
        rst = 1'b1;
        apply_stimulus(16'hAF64, 1'b1, '{1'b0, 4'b1110, 8'h99});
        #1;
        check_output("in_reset");

        // Reset release followed by a full scan and wrap back to digit 0.
        do_reset();
        for (int k = 0; k < 17; k++) begin
            apply_stimulus(vecs[k].data, vecs[k].enable, '{1'b0, vecs[k].anode, vecs[k].seg});
            #1;
            check_output("scan");
            step();
        end

        // Blanking keeps the scan counting underneath.
        do_reset();
        for (int k = 0; k < 23; k++) begin
            logic en;
            en = !(k >= 10 && k < 15);
            apply_stimulus(16'h1234, en, model(16'h1234, en, cyc));
            #1;
            check_output(en ? "blank_enabled" : "blank_off");
            step();
        end

        // Encoding sweep with reset held so digit 0 stays selected.
        rst = 1'b1;
        for (int v = 0; v < 16; v++) begin
            logic [3:0] nib;
            nib = 4'(v);
            apply_stimulus({12'hABC, nib}, 1'b1, '{1'b0, 4'b1110, hex_table[v]});
            #1;
            check_output("encode");
            checks++;
            if (bus4.seg[7] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL encode_dp seg7 got %b want 1", bus4.seg[7]);
            end
            #3;
        end

        // Asynchronous reset while digit 2 is lit.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            apply_stimulus(16'hAF64, 1'b1, model(16'hAF64, 1'b1, cyc));
            #1;
            check_output("pre_async");
            step();
        end
        apply_stimulus(16'hAF64, 1'b1, '{1'b0, 4'b1011, 8'h8E});
        #1;
        check_output("digit2_lit");
        rst = 1'b1;
        apply_stimulus(16'hAF64, 1'b1, '{1'b0, 4'b1110, 8'h99});
        #1;
        check_output("async_rst");
        step();
        rst = 1'b0;
        cyc = 0;
        for (int k = 0; k < 5; k++) begin
            e = (k < 4) ? '{1'b0, 4'b1110, 8'h99} : '{1'b0, 4'b1101, 8'h82};
            apply_stimulus(16'hAF64, 1'b1, e);
            #1;
            check_output("post_async");
            step();
        end

        // Data change on the lit digit shows up without a clock edge.
        do_reset();
        for (int k = 0; k < 4; k++) step();
        apply_stimulus(16'h0000, 1'b1, '{1'b0, 4'b1101, 8'hC0});
        #1;
        check_output("live_before");
        apply_stimulus(16'h00B0, 1'b1, '{1'b0, 4'b1101, 8'h83});
        #1;
        check_output("live_after");

        // Single-cycle dwell rotates every clock.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            apply_stimulus(16'h4321, 1'b1, '{1'b1, fast_anodes[k], fast_segs[k]});
            #1;
            check_output("fast_scan");
            step();
        end

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_drain leftover got %0d want 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
